// File: rtl/seq_frame_tx_pkg.sv
// Shared definitions for the serial sync-pattern framing: state encoding,
// preamble pattern and minimum idle gap, common to transmitter and receiver.
package seq_frame_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE_A = 3'd1,
    S_PRE_B = 3'd2,
    S_PRE_C = 3'd3,
    S_DATA  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  localparam logic [2:0] PREAMBLE     = 3'b101;
  localparam int         PREAMBLE_LEN = 3;

  // Two idle zeros stop a payload ending in "1" or "10" from joining the next
  // preamble into a spurious "101".
  localparam int         GAP_MIN      = 2;

endpackage

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble 101, DATA_W payload bits MSB first, GAP zeros.
// One word per frame; in_ready only in IDLE, nothing is queued.
module seq_frame_tx
  import seq_frame_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              sync,
  output logic              done
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam int GCW = $clog2(GAP + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP - 1);

  if (GAP < GAP_MIN) begin : g_bad_gap
    $error("seq_frame_tx: GAP must be at least GAP_MIN");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("seq_frame_tx: DATA_W must be at least 1");
  end

  state_t            r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [BCW-1:0]    r_bcnt;
  logic [GCW-1:0]    r_gcnt;
  logic              r_out;
  logic              r_busy;
  logic              r_sync;
  logic              r_done;

  state_t            w_state_nxt;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic [BCW-1:0]    w_bcnt_nxt;
  logic [GCW-1:0]    w_gcnt_nxt;
  logic              w_out_nxt;
  logic              w_busy_nxt;
  logic              w_sync_nxt;
  logic              w_done_nxt;
  logic              w_accept;

  assign in_ready = (r_state == S_IDLE) && !reset;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_bcnt_nxt  = r_bcnt;
    w_gcnt_nxt  = r_gcnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_PRE_A;
          w_shreg_nxt = in_data;
          w_bcnt_nxt  = '0;
          w_gcnt_nxt  = '0;
        end
      end
      S_PRE_A: w_state_nxt = S_PRE_B;
      S_PRE_B: w_state_nxt = S_PRE_C;
      S_PRE_C: begin
        w_state_nxt = S_DATA;
        w_bcnt_nxt  = '0;
      end
      S_DATA: begin
        w_shreg_nxt = r_shreg << 1;
        w_bcnt_nxt  = r_bcnt + 1'b1;
        if (r_bcnt == BIT_LAST) begin
          w_state_nxt = S_GAP;
          w_gcnt_nxt  = '0;
        end
      end
      S_GAP: begin
        w_gcnt_nxt = r_gcnt + 1'b1;
        if (r_gcnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in the same cycle
  // as the state they describe.
  always_comb begin
    w_out_nxt = 1'b0;
    case (w_state_nxt)
      S_PRE_A: w_out_nxt = PREAMBLE[2];
      S_PRE_B: w_out_nxt = PREAMBLE[1];
      S_PRE_C: w_out_nxt = PREAMBLE[0];
      S_DATA:  w_out_nxt = w_shreg_nxt[DATA_W-1];
      default: w_out_nxt = 1'b0;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_sync_nxt = (w_state_nxt == S_PRE_C);
    w_done_nxt = (w_state_nxt == S_GAP) && (w_gcnt_nxt == GAP_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_bcnt  <= '0;
      r_gcnt  <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_sync  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= w_busy_nxt;
      r_sync  <= w_sync_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign sync = r_sync;
  assign done = r_done;

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter: the send side of the team's serial sync-pattern detectors.
- Accepts a parallel word over a valid/ready handshake and emits one bit per clock on `out`.
- Frame format: preamble 1,0,1, then DATA_W data bits MSB first, then GAP idle zeros.
- A downstream "101" Moore detector asserts on the third preamble bit. The GAP zeros keep the previous frame's tail from forming a false preamble with the next frame.

Parameters:
- DATA_W, 8: payload width in bits. Legal range is 1 or more.
- GAP, 2: idle-zero cycles after the payload. Legal range is 2 or more; elaboration-time check.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  payload word offered
- in_data  in  DATA_W  payload word; sampled only on accept
- in_ready  out  1  combinational; (state==IDLE) && !reset
- out  out  1  serial line, registered
- busy  out  1  registered; high in every state except IDLE
- sync  out  1  registered; high during the cycle `out` carries the third preamble bit
- done  out  1  registered; one-cycle pulse during the last GAP cycle

Behaviour:
- Reset: clk-synchronous, overrides all other activity.
  - state=IDLE.
  - out, busy, sync, done = 0.
  - Shift register and counters = 0.
  - Reset mid-frame aborts the frame immediately. `out` is 0 from the first cycle after the reset edge. No partial frame resumes.
- States: IDLE, PRE_A, PRE_B, PRE_C, DATA, GAP. The encoding is a package enum.
- Accept: at a rising edge where in_valid && in_ready.
  - in_data is loaded into the shift register.
  - state goes to PRE_A.
  - in_data and in_valid are ignored in all other states. Nothing is queued.
- Transitions:
  - IDLE goes to PRE_A on accept, else stays in IDLE.
  - PRE_A goes to PRE_B, and PRE_B goes to PRE_C.
  - PRE_C goes to DATA, with bit counter=0.
  - DATA shifts left each cycle and increments the counter. At counter==DATA_W-1 it goes to GAP, with gap counter=0.
  - GAP increments its counter. At counter==GAP-1 it goes to IDLE.
- Output values (Moore, registered alongside the state):
  - `out` = 1 in PRE_A, 0 in PRE_B, 1 in PRE_C.
  - `out` = shreg[DATA_W-1] in DATA.
  - `out` = 0 in IDLE and GAP.
- Latency and timing:
  - `out`=1 (first preamble bit) in the cycle immediately after the accept edge.
  - Frame length is 3+DATA_W+GAP cycles.
  - in_ready returns high on the first IDLE cycle after the frame.
  - Minimum back-to-back period is 4+DATA_W+GAP cycles.
- sync=1 only in PRE_C. done=1 only in the final GAP cycle. Each is exactly one cycle per frame.
- Data content is not escaped. A "101" inside the payload is transmitted as-is, and payload framing is the receiver's concern.
- in_valid held high while busy has no effect. A new accept occurs at the first IDLE edge.
- Width rules:
  - Bit counter is $clog2(DATA_W+1) bits.
  - Gap counter is $clog2(GAP+1) bits.
  - Neither counter ever wraps.

Decomposition:
- Shared package holds:
  - the state enum with explicit encoding;
  - the preamble constant PREAMBLE=3'b101 and its length;
  - the GAP_MIN=2 constant.
- These are shared with the matching detector/receiver.
- No sub-module is needed. A single module with one next-state always block, one sequential block and registered outputs is sufficient.

Test Plan:
- DATA_W=8, GAP=2. Reset, then accept 0xA5 at edge 0 → `out` over cycles 1..13 = 1,0,1,1,0,1,0,0,1,0,1,0,0. sync high only in cycle 3. done high only in cycle 13. in_ready high in cycle 14.
- Payload 0x00, then 0xFF, sent back-to-back with in_valid held high → each frame is 13 bits with exactly 1 idle cycle between frames. A reference "101" detector fires exactly once per frame for 0x00. For 0xFF it also fires only on the preambles, confirming the GAP zeros prevent a tail-induced false detect.
- in_valid pulsed with 0x3C during the DATA state of a 0x81 frame → ignored. The 0x81 frame is unchanged, and no second frame starts.
- reset asserted for 1 cycle at cycle 6 of a frame → the next cycle shows out=0, busy=0, in_ready=1. No sync or done is produced. A new accept afterward produces a clean full frame.
- DATA_W=1, GAP=2, payload 1 → `out` = 1,0,1,1,0,0 and the frame length is 6. Elaborating with GAP=1 fails the parameter check.
